// File: rtl/sii_ncu_xfer_arb.sv
// sii_ncu_xfer_arb: round-robin Mondo/PIO arbiter and req/gnt sequencer driving 1 header + 4 payload beats to NCU
// Ports: iol2clk/rst clock and sync reset; mondo_* and pio_* source vld/hdr/pl in, ack out;
// sii_ncu_req out, ncu_sii_gnt in; sii_ncu_data/sii_ncu_dparity beat out; xfer_busy, gnt_to_err status.
// Build option SII_NCU_XFER_STATS_EN adds mondo_cnt/pio_cnt saturating transfer counters.
`timescale 1ns/1ps
module sii_ncu_xfer_arb #(
  parameter int GNT_TO_CYC = 1023
`ifdef SII_NCU_XFER_STATS_EN
  ,
  parameter int CNT_W = 16
`endif
) (
  input  logic         iol2clk,
  input  logic         rst,
  input  logic         mondo_vld,
  input  logic [31:0]  mondo_hdr,
  input  logic [127:0] mondo_pl,
  output logic         mondo_ack,
  input  logic         pio_vld,
  input  logic [31:0]  pio_hdr,
  input  logic [127:0] pio_pl,
  output logic         pio_ack,
  output logic         sii_ncu_req,
  input  logic         ncu_sii_gnt,
  output logic [31:0]  sii_ncu_data,
  output logic [1:0]   sii_ncu_dparity,
  output logic         xfer_busy,
  output logic         gnt_to_err
`ifdef SII_NCU_XFER_STATS_EN
  ,
  output logic [CNT_W-1:0] mondo_cnt,
  output logic [CNT_W-1:0] pio_cnt
`endif
);
  localparam int TW = $clog2(GNT_TO_CYC + 2);
  typedef enum logic [2:0] {IDLE, REQ, HDR, PL0, PL1, PL2, PL3} state_t;
  state_t state, nxt;
  logic lw_pio;
  logic [31:0] hdr_q;
  logic [127:0] pl_q;
  logic [TW-1:0] tcnt;
  logic take, pick_m, to_hit;
  logic [31:0] beat;
  always_comb begin
    take = (state == IDLE || state == PL3) && (mondo_vld || pio_vld);
    pick_m = mondo_vld && (!pio_vld || lw_pio);
    nxt = take ? REQ :
          state == REQ ? (ncu_sii_gnt ? HDR : REQ) :
          (state == IDLE || state == PL3) ? IDLE : state_t'(state + 3'd1);
    beat = (state == REQ && ncu_sii_gnt) ? hdr_q :
           state == HDR ? pl_q[127:96] :
           state == PL0 ? pl_q[95:64] :
           state == PL1 ? pl_q[63:32] :
           state == PL2 ? pl_q[31:0] : '0;
    to_hit = GNT_TO_CYC != 0 && state == REQ && !ncu_sii_gnt && int'(tcnt) == GNT_TO_CYC - 1;
  end
  always_ff @(posedge iol2clk) begin
    if (rst) begin
      state <= IDLE;
      lw_pio <= 1'b1;
      hdr_q <= '0;
      pl_q <= '0;
      tcnt <= '0;
      mondo_ack <= 1'b0;
      pio_ack <= 1'b0;
      sii_ncu_req <= 1'b0;
      sii_ncu_data <= '0;
      sii_ncu_dparity <= '0;
      xfer_busy <= 1'b0;
      gnt_to_err <= 1'b0;
    end else begin
      state <= nxt;
      mondo_ack <= take && pick_m;
      pio_ack <= take && !pick_m;
      sii_ncu_req <= nxt == REQ;
      xfer_busy <= nxt != IDLE;
      sii_ncu_data <= beat;
      sii_ncu_dparity <= {^beat[31:16], ^beat[15:0]};
      gnt_to_err <= gnt_to_err || to_hit;
      if (take) begin
        hdr_q <= pick_m ? mondo_hdr : pio_hdr;
        pl_q <= pick_m ? mondo_pl : pio_pl;
        lw_pio <= !pick_m;
        tcnt <= '0;
      end else if (state == REQ && int'(tcnt) < GNT_TO_CYC) begin
        tcnt <= tcnt + TW'(1);
      end
    end
  end
`ifdef SII_NCU_XFER_STATS_EN
  always_ff @(posedge iol2clk) begin
    if (rst) begin
      mondo_cnt <= '0;
      pio_cnt <= '0;
    end else if (state == PL3) begin
      if (!lw_pio && !(&mondo_cnt)) mondo_cnt <= mondo_cnt + CNT_W'(1);
      if (lw_pio && !(&pio_cnt)) pio_cnt <= pio_cnt + CNT_W'(1);
    end
  end
`endif
endmodule

// File: tb/tb_sii_ncu_xfer_arb.sv
// tb_sii_ncu_xfer_arb: scoreboard bench for sii_ncu_xfer_arb (beats queued at capture, popped as driven)
`timescale 1ns/1ps
module tb_sii_ncu_xfer_arb;
  localparam int TO = 8;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic mondo_vld = 1'b0, pio_vld = 1'b0, gnt = 1'b0;
  logic [31:0] mondo_hdr = '0, pio_hdr = '0;
  logic [127:0] mondo_pl = '0, pio_pl = '0;
  logic mondo_ack, pio_ack, req, busy, err;
  logic [31:0] data;
  logic [1:0] dpar;
`ifdef SII_NCU_XFER_STATS_EN
  logic [1:0] mondo_cnt, pio_cnt;
`endif
  int passes = 0, total = 0;
  int cm = 0, cp = 0;
  bit err_exp = 1'b0;
  logic [31:0] exp_q[$];
  sii_ncu_xfer_arb #(
    .GNT_TO_CYC(TO)
`ifdef SII_NCU_XFER_STATS_EN
    ,
    .CNT_W(2)
`endif
  ) dut (
    .iol2clk(clk),
    .rst(rst),
    .mondo_vld(mondo_vld),
    .mondo_hdr(mondo_hdr),
    .mondo_pl(mondo_pl),
    .mondo_ack(mondo_ack),
    .pio_vld(pio_vld),
    .pio_hdr(pio_hdr),
    .pio_pl(pio_pl),
    .pio_ack(pio_ack),
    .sii_ncu_req(req),
    .ncu_sii_gnt(gnt),
    .sii_ncu_data(data),
    .sii_ncu_dparity(dpar),
    .xfer_busy(busy),
    .gnt_to_err(err)
`ifdef SII_NCU_XFER_STATS_EN
    ,
    .mondo_cnt(mondo_cnt),
    .pio_cnt(pio_cnt)
`endif
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  function automatic logic [1:0] par(input logic [31:0] b);
    return {^b[31:16], ^b[15:0]};
  endfunction
  task automatic chk_idle(input string tag);
    chk({tag, "_data"}, data, 0);
    chk({tag, "_dpar"}, dpar, 0);
    chk({tag, "_req"}, req, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask
  task automatic chk_stats(input string tag);
`ifdef SII_NCU_XFER_STATS_EN
    chk({tag, "_mcnt"}, mondo_cnt, cm);
    chk({tag, "_pcnt"}, pio_cnt, cp);
`endif
  endtask
  task automatic do_xfer(input bit is_m, input int gap, input bit keep);
    logic [127:0] pl;
    logic [31:0] b;
    pl = is_m ? mondo_pl : pio_pl;
    exp_q.push_back(is_m ? mondo_hdr : pio_hdr);
    for (int k = 0; k < 4; k++) exp_q.push_back(pl[127-32*k -: 32]);
    @(negedge clk);
    chk("mondo_ack", mondo_ack, is_m);
    chk("pio_ack", pio_ack, !is_m);
    chk("req_on", req, 1);
    chk("busy_on", busy, 1);
    chk("err_req", err, err_exp);
    if (is_m) begin
      mondo_hdr = mondo_hdr + 32'h10;
      mondo_pl = {$urandom, $urandom, $urandom, $urandom};
    end else begin
      pio_hdr = pio_hdr + 32'h10;
      pio_pl = {$urandom, $urandom, $urandom, $urandom};
    end
    if (!keep) begin
      mondo_vld = 1'b0;
      pio_vld = 1'b0;
    end
    for (int c = 2; c <= gap + 1; c++) begin
      @(negedge clk);
      if (c > TO) err_exp = 1'b1;
      chk("ack_pulse", {mondo_ack, pio_ack}, 0);
      chk("req_hold", req, 1);
      chk("err_wait", err, err_exp);
    end
    gnt = 1'b1;
    @(negedge clk);
    gnt = 1'b0;
    chk("req_off", req, 0);
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clk);
      b = exp_q.pop_front();
      chk(k == 0 ? "hdr_beat" : "pl_beat", data, b);
      chk("dparity", dpar, par(b));
      chk("err_beat", err, err_exp);
    end
    if (is_m) cm = cm < 3 ? cm + 1 : cm;
    else cp = cp < 3 ? cp + 1 : cp;
  endtask
  initial begin
    repeat (3) @(negedge clk);
    chk_idle("rst");
    chk("rst_acks", {mondo_ack, pio_ack}, 0);
    chk("rst_err", err, 0);
    chk_stats("rst");
    rst = 1'b0;
    gnt = 1'b1;
    @(negedge clk);
    gnt = 1'b0;
    chk_idle("gnt_idle");
    @(negedge clk);
    chk_idle("gnt_idle2");
    mondo_hdr = 32'hB000_0000;
    pio_hdr = 32'hC000_0000;
    mondo_pl = {$urandom, $urandom, $urandom, $urandom};
    pio_pl = {$urandom, $urandom, $urandom, $urandom};
    mondo_vld = 1'b1;
    pio_vld = 1'b1;
    for (int i = 0; i < 4; i++) begin
      do_xfer(i % 2 == 0, 0, 1'b1);
      if (i == 3) begin
        mondo_vld = 1'b0;
        pio_vld = 1'b0;
      end
    end
    @(negedge clk);
    chk_idle("rr_end");
    chk_stats("rr");
    mondo_hdr = 32'hA5A5_0001;
    mondo_pl = 128'h11111111_22222222_33333333_44444444;
    mondo_vld = 1'b1;
    do_xfer(1'b1, 2, 1'b0);
    @(negedge clk);
    chk_idle("t1_end");
    pio_hdr = 32'h0001_0000;
    pio_pl = 128'hFFFFFFFF_00000000_00008001_00030001;
    pio_vld = 1'b1;
    do_xfer(1'b0, 1, 1'b0);
    @(negedge clk);
    chk_idle("t3_end");
    mondo_vld = 1'b1;
    do_xfer(1'b1, 12, 1'b0);
    @(negedge clk);
    chk_idle("t4_end");
    repeat (3) @(negedge clk);
    chk("err_sticky", err, 1);
    chk_stats("sat");
    mondo_vld = 1'b1;
    @(negedge clk);
    mondo_vld = 1'b0;
    chk("t5_ack", mondo_ack, 1);
    gnt = 1'b1;
    @(negedge clk);
    gnt = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("t5_pl1_busy", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    err_exp = 1'b0;
    cm = 0;
    cp = 0;
    chk_idle("t5_rst");
    chk("t5_acks", {mondo_ack, pio_ack}, 0);
    chk("t5_err", err, 0);
    gnt = 1'b1;
    @(negedge clk);
    gnt = 1'b0;
    chk_idle("t5_gnt");
    @(negedge clk);
    chk_idle("t5_gnt2");
    chk_stats("t5");
    mondo_vld = 1'b1;
    pio_vld = 1'b1;
    do_xfer(1'b1, 0, 1'b0);
    @(negedge clk);
    chk_idle("post_end");
    chk_stats("post");
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
